satagtx_rst_seq: RTL and testbench

Power-up and recovery reset sequencer for the SATA GTX tile and its user-clock DCM/PLL. It holds the GTX in reset and waits for the tile PLL lock. It then releases the user-clock DCM/PLL reset, waits for that lock, and pulses the TX/RX datapath resets until reset-done is reported. It monitors for lock loss, retries with timeouts, and reports ready or fail to the SATA link layer. It sits beside the GTX clocking block and runs on a free-running system clock.

---
 rtl/satagtx_rst_seq.sv | 174 +++++++++++++++++
 tb/tb_satagtx_rst_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/satagtx_rst_seq.sv
// Reset sequencer for a SATA GTX tile and its user-clock DCM/PLL: brings up the tile PLL,
// the user clock and the TX/RX PCS in order, retries on lock loss or timeout, and reports ready/fail.
module satagtx_rst_seq #(
  parameter int unsigned C_RST_CYCLES     = 64,
  parameter int unsigned C_LOCK_STABLE    = 256,
  parameter int unsigned C_PLL_TIMEOUT    = 65535,
  parameter int unsigned C_DCM_TIMEOUT    = 65535,
  parameter int unsigned C_USR_RST_CYCLES = 16,
  parameter int unsigned C_DONE_TIMEOUT   = 65535,
  parameter int unsigned C_MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       plllkdet,
  input  logic       dcm_locked,
  input  logic [1:0] resetdone,
  input  logic       restart,
  output logic       gtxreset,
  output logic       dcm_reset,
  output logic       txreset,
  output logic       rxreset,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_PLL  = 3'd1,
    S_WAIT_DCM  = 3'd2,
    S_USR_RST   = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_READY     = 3'd5,
    S_FAIL      = 3'd6
  } state_e;

  // Terminal counts: a state is left on the edge where cnt_q holds its last value.
  localparam logic [15:0] RST_LAST    = 16'(C_RST_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST = 16'(C_LOCK_STABLE - 1);
  localparam logic [15:0] PLL_LAST    = 16'(C_PLL_TIMEOUT - 1);
  localparam logic [15:0] DCM_LAST    = 16'(C_DCM_TIMEOUT - 1);
  localparam logic [15:0] USR_LAST    = 16'(C_USR_RST_CYCLES - 1);
  localparam logic [15:0] DONE_LAST   = 16'(C_DONE_TIMEOUT - 1);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Two-flop synchronisers for {resetdone[1:0], dcm_locked, plllkdet}
  logic [3:0] sync_p0_q, sync_p1_q;
  logic       pll_s, dcm_s, lock_s;
  logic [1:0] done_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0_q <= '0;
      sync_p1_q <= '0;
    end else begin
      sync_p0_q <= {resetdone, dcm_locked, plllkdet};
      sync_p1_q <= sync_p0_q;
    end
  end

  assign pll_s  = sync_p1_q[0];
  assign dcm_s  = sync_p1_q[1];
  assign done_s = sync_p1_q[3:2];
  assign lock_s = pll_s & dcm_s;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, stab_q, stab_d;
  logic [3:0]  retry_q, retry_d;
  logic        do_retry, entering;
  logic        gtx_q, dcm_q, tx_q, rx_q, ready_q, fail_q;
  logic        gtx_d, dcm_d, tx_d, rx_d, ready_d, fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      gtx_q   <= 1'b1;
      dcm_q   <= 1'b1;
      tx_q    <= 1'b1;
      rx_q    <= 1'b1;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      gtx_q   <= gtx_d;
      dcm_q   <= dcm_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
    end
  end

  // Lock loss is tested before success or timeout so a lost lock always wins and counts once.
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    do_retry = 1'b0;
    case (state_q)
      S_RESET:     if (cnt_q == RST_LAST) state_d = S_WAIT_PLL;
      S_WAIT_PLL:  if (pll_s && stab_q == STABLE_LAST) state_d = S_WAIT_DCM;
                   else if (cnt_q == PLL_LAST) do_retry = 1'b1;
      S_WAIT_DCM:  if (!pll_s) do_retry = 1'b1;
                   else if (dcm_s) state_d = S_USR_RST;
                   else if (cnt_q == DCM_LAST) do_retry = 1'b1;
      S_USR_RST:   if (!lock_s) do_retry = 1'b1;
                   else if (cnt_q == USR_LAST) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!lock_s) do_retry = 1'b1;
                   else if (done_s == 2'b11) state_d = S_READY;
                   else if (cnt_q == DONE_LAST) do_retry = 1'b1;
      S_READY:     if (!lock_s) do_retry = 1'b1;
                   else if (done_s != 2'b11) state_d = S_USR_RST;
      S_FAIL:      state_d = S_FAIL;
      default:     state_d = S_RESET;
    endcase
    if (do_retry) begin
      retry_d = sat_inc4(retry_q);
      state_d = (32'(retry_d) > C_MAX_RETRY) ? S_FAIL : S_RESET;
    end
    if (state_d == S_READY && state_q != S_READY) retry_d = '0;
    if (restart) begin
      state_d = S_RESET;
      retry_d = '0;
    end
  end

  always_comb begin
    entering = restart || (state_d != state_q);
    cnt_d    = entering ? '0 : sat_inc16(cnt_q);
    stab_d   = '0;
    if (!entering && state_q == S_WAIT_PLL && pll_s) stab_d = sat_inc16(stab_q);
  end

  // Outputs decoded from the next state so they register in step with state_q.
  always_comb begin
    {gtx_d, dcm_d, tx_d, rx_d} = 4'b1111;
    ready_d = 1'b0;
    fail_d  = 1'b0;
    case (state_d)
      S_WAIT_PLL:           {gtx_d, dcm_d, tx_d, rx_d} = 4'b0111;
      S_WAIT_DCM, S_USR_RST: {gtx_d, dcm_d, tx_d, rx_d} = 4'b0011;
      S_WAIT_DONE:          {gtx_d, dcm_d, tx_d, rx_d} = 4'b0000;
      S_READY: begin
        {gtx_d, dcm_d, tx_d, rx_d} = 4'b0000;
        ready_d = 1'b1;
      end
      S_FAIL:               fail_d = 1'b1;
      default: ;
    endcase
  end

  assign gtxreset  = gtx_q;
  assign dcm_reset = dcm_q;
  assign txreset   = tx_q;
  assign rxreset   = rx_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_satagtx_rst_seq.sv
// Bench for satagtx_rst_seq: directed bring-up/recovery scenarios plus random lock/done activity,
// all checked against a cycle-level behavioural model of the sequencing rules.
module tb_satagtx_rst_seq;

  localparam int RST  = 4;
  localparam int STB  = 8;
  localparam int PTO  = 20;
  localparam int DTO  = 30;
  localparam int USR  = 4;
  localparam int NTO  = 30;
  localparam int MAXR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, plllkdet, dcm_locked, restart;
  logic [1:0] resetdone;
  logic       gtxreset, dcm_reset, txreset, rxreset, ready, fail;
  logic [2:0] st;
  logic [3:0] rcnt;

  int total = 0;
  int bad   = 0;

  satagtx_rst_seq #(
    .C_RST_CYCLES(RST), .C_LOCK_STABLE(STB), .C_PLL_TIMEOUT(PTO), .C_DCM_TIMEOUT(DTO),
    .C_USR_RST_CYCLES(USR), .C_DONE_TIMEOUT(NTO), .C_MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .plllkdet(plllkdet), .dcm_locked(dcm_locked),
    .resetdone(resetdone), .restart(restart), .gtxreset(gtxreset), .dcm_reset(dcm_reset),
    .txreset(txreset), .rxreset(rxreset), .ready(ready), .fail(fail), .state(st),
    .retry_cnt(rcnt)
  );

  // Behavioural model: phase, cycles spent in phase, consecutive PLL-high count, retries.
  int         m_state, m_cnt, m_stab, m_retry;
  logic [3:0] m_q[$];

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_stab = 0; m_retry = 0;
    m_q = {4'b0000, 4'b0000};
  endtask

  task automatic model_edge();
    logic [3:0] s;
    int         nxt;
    bit         rty, locked;
    s = m_q.pop_front();
    m_q.push_back({resetdone, dcm_locked, plllkdet});
    locked = s[0] && s[1];
    nxt = m_state;
    rty = 0;
    if (restart) begin
      nxt = 0;
      m_retry = 0;
    end else begin
      case (m_state)
        0: if (m_cnt + 1 >= RST) nxt = 1;
        1: begin
          m_stab = s[0] ? m_stab + 1 : 0;
          if (m_stab >= STB) nxt = 2;
          else if (m_cnt + 1 >= PTO) rty = 1;
        end
        2: if (!s[0]) rty = 1; else if (s[1]) nxt = 3; else if (m_cnt + 1 >= DTO) rty = 1;
        3: if (!locked) rty = 1; else if (m_cnt + 1 >= USR) nxt = 4;
        4: begin
          if (!locked) rty = 1;
          else if (s[3:2] == 2'b11) begin nxt = 5; m_retry = 0; end
          else if (m_cnt + 1 >= NTO) rty = 1;
        end
        5: if (!locked) rty = 1; else if (s[3:2] != 2'b11) nxt = 3;
        default: ;
      endcase
      if (rty) begin
        if (m_retry < 15) m_retry++;
        nxt = (m_retry > MAXR) ? 6 : 0;
      end
    end
    if (restart || nxt != m_state) begin
      m_cnt = 0;
      m_stab = 0;
    end else begin
      m_cnt++;
    end
    m_state = nxt;
  endtask

  function automatic logic [12:0] exp_out();
    logic [3:0] r;
    case (m_state)
      1:       r = 4'b0111;
      2, 3:    r = 4'b0011;
      4, 5:    r = 4'b0000;
      default: r = 4'b1111;
    endcase
    return {3'(m_state), 4'(m_retry), r, m_state == 5, m_state == 6};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {st, rcnt, gtxreset, dcm_reset, txreset, rxreset, ready, fail};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic p, input logic d, input logic [1:0] r);
    plllkdet = p; dcm_locked = d; resetdone = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    restart = 1'b0;
    drive(1'b1, 1'b1, 2'b11);
    model_reset();
    repeat (3) step();
    total++;
    if (dut_vec() !== 13'b000_0000_1111_00) begin
      bad++; $display("FAIL reset_vals got=%b exp=%b", dut_vec(), 13'b000_0000_1111_00);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_power_up();
    int t_gtx = -1;
    int t_dcm = -1;
    int t_rdy = -1;
    for (int c = 1; c <= 80; c++) begin
      step();
      total++;
      if (dut_vec() !== exp_out()) begin
        bad++; $display("FAIL powerup c=%0d got=%h exp=%h", c, dut_vec(), exp_out());
      end
      if (t_gtx < 0 && gtxreset === 1'b0) t_gtx = c;
      if (t_dcm < 0 && dcm_reset === 1'b0) t_dcm = c;
      if (ready === 1'b1) begin t_rdy = c; break; end
    end
    total++;
    if (t_gtx != RST) begin bad++; $display("FAIL gtx_release got=%0d exp=%0d", t_gtx, RST); end
    total++;
    if (t_dcm - t_gtx < STB || t_dcm - t_gtx > STB + 2) begin
      bad++; $display("FAIL dcm_release got=%0d exp=%0d..%0d", t_dcm - t_gtx, STB, STB + 2);
    end
    total++;
    if (t_rdy < 0 || rcnt !== 4'd0) begin
      bad++; $display("FAIL ready_up got ready_at=%0d retry=%0d exp retry=0", t_rdy, rcnt);
    end
  endtask

  task automatic test_glitch();
    int fall = -1;
    restart = 1'b1; step(); restart = 1'b0;
    total++;
    if (dut_vec() !== exp_out() || st !== 3'd0) begin
      bad++; $display("FAIL glitch_restart got=%h exp=%h", dut_vec(), exp_out());
    end
    for (int c = 0; c < 20 && st !== 3'd1; c++) step();
    total++;
    if (st !== 3'd1) begin bad++; $display("FAIL glitch_enter got=%0d exp=1", st); end
    repeat (5) begin
      step(); total++;
      if (dut_vec() !== exp_out()) begin bad++; $display("FAIL glitch_hi got=%h exp=%h", dut_vec(), exp_out()); end
    end
    plllkdet = 1'b0; step(); plllkdet = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step(); total++;
      if (dut_vec() !== exp_out()) begin bad++; $display("FAIL glitch_c%0d got=%h exp=%h", c, dut_vec(), exp_out()); end
      if (fall < 0 && dcm_reset === 1'b0) fall = c;
    end
    total++;
    if (fall < STB || fall > STB + 2) begin
      bad++; $display("FAIL glitch_dcm_fall got=%0d exp=%0d..%0d", fall, STB, STB + 2);
    end
  endtask

  task automatic test_timeout();
    int seq[$];
    int first = -1;
    logic [3:0] prev;
    drive(1'b0, 1'b1, 2'b11);
    restart = 1'b1; step(); restart = 1'b0;
    prev = rcnt;
    for (int c = 1; c <= 200 && fail !== 1'b1; c++) begin
      step(); total++;
      if (dut_vec() !== exp_out()) begin bad++; $display("FAIL timeout_c%0d got=%h exp=%h", c, dut_vec(), exp_out()); end
      if (rcnt !== prev) begin
        seq.push_back(int'(rcnt));
        if (first < 0) first = c;
        prev = rcnt;
      end
    end
    total++;
    if (first != RST + PTO) begin bad++; $display("FAIL timeout_first got=%0d exp=%0d", first, RST + PTO); end
    total++;
    if (seq.size() != MAXR + 1) begin
      bad++; $display("FAIL timeout_count got=%0d exp=%0d", seq.size(), MAXR + 1);
    end else begin
      for (int i = 0; i <= MAXR; i++) begin
        total++;
        if (seq[i] != i + 1) begin bad++; $display("FAIL timeout_seq%0d got=%0d exp=%0d", i, seq[i], i + 1); end
      end
    end
    repeat (5) step();
    total++;
    if ({st, fail, ready, gtxreset, dcm_reset, txreset, rxreset} !== {3'd6, 6'b10_1111}) begin
      bad++; $display("FAIL fail_hold got=%b exp=%b", {st, fail, ready, gtxreset, dcm_reset, txreset, rxreset}, {3'd6, 6'b10_1111});
    end
    restart = 1'b1; step(); restart = 1'b0;
    total++;
    if ({st, fail, rcnt} !== 8'b000_0_0000) begin
      bad++; $display("FAIL fail_restart got=%b exp=%b", {st, fail, rcnt}, 8'b000_0_0000);
    end
    plllkdet = 1'b1;
  endtask

  task automatic run_to_ready(input string tag);
    for (int c = 0; c < 80 && ready !== 1'b1; c++) begin
      step(); total++;
      if (dut_vec() !== exp_out()) begin bad++; $display("FAIL %s got=%h exp=%h", tag, dut_vec(), exp_out()); end
    end
    total++;
    if (ready !== 1'b1 || rcnt !== 4'd0) begin
      bad++; $display("FAIL %s_ready got ready=%b retry=%0d exp ready=1 retry=0", tag, ready, rcnt);
    end
  endtask

  task automatic test_dcm_drop();
    int drop = -1;
    drive(1'b1, 1'b1, 2'b11);
    run_to_ready("dcmdrop_pre");
    dcm_locked = 1'b0; step(); dcm_locked = 1'b1;
    if (ready === 1'b0) drop = 1;
    for (int k = 2; k <= 3; k++) begin
      step(); total++;
      if (dut_vec() !== exp_out()) begin bad++; $display("FAIL dcmdrop_k%0d got=%h exp=%h", k, dut_vec(), exp_out()); end
      if (drop < 0 && ready === 1'b0) drop = k;
    end
    total++;
    if (drop < 0 || st !== 3'd0 || rcnt !== 4'd1) begin
      bad++; $display("FAIL dcmdrop_recover got drop=%0d state=%0d retry=%0d exp state=0 retry=1", drop, st, rcnt);
    end
    run_to_ready("dcmdrop_post");
  endtask

  task automatic test_done_drop();
    int pulse = 0;
    resetdone = 2'b01;
    for (int c = 0; c < 5 && st !== 3'd3; c++) begin
      step(); total++;
      if (dut_vec() !== exp_out()) begin bad++; $display("FAIL donedrop_wait got=%h exp=%h", dut_vec(), exp_out()); end
    end
    resetdone = 2'b11;
    if (st === 3'd3 && txreset === 1'b1 && rxreset === 1'b1) pulse = 1;
    for (int c = 0; c < 20 && st === 3'd3; c++) begin
      step(); total++;
      if (dut_vec() !== exp_out()) begin bad++; $display("FAIL donedrop_usr got=%h exp=%h", dut_vec(), exp_out()); end
      if (st === 3'd3 && txreset === 1'b1 && rxreset === 1'b1) pulse++;
    end
    total++;
    if (pulse != USR || rcnt !== 4'd0) begin
      bad++; $display("FAIL donedrop_pulse got len=%0d retry=%0d exp len=%0d retry=0", pulse, rcnt, USR);
    end
    run_to_ready("donedrop_post");
  endtask

  task automatic test_async_reset();
    resetdone = 2'b00;
    restart = 1'b1; step(); restart = 1'b0;
    for (int c = 0; c < 40 && st !== 3'd4; c++) step();
    total++;
    if (st !== 3'd4) begin bad++; $display("FAIL areset_reach got=%0d exp=4", st); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({st, gtxreset, dcm_reset, txreset, rxreset, ready} !== 8'b000_1111_0) begin
      bad++; $display("FAIL areset_vals got=%b exp=%b", {st, gtxreset, dcm_reset, txreset, rxreset, ready}, 8'b000_1111_0);
    end
    model_reset();
    resetdone = 2'b11;
    step();
    rst_n = 1'b1;
    run_to_ready("areset_post");
  endtask

  task automatic test_random();
    int hp = 0, hd = 0, hr = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hp == 0) begin plllkdet = ($urandom_range(0, 9) < 8); hp = $urandom_range(1, 40); end
      if (hd == 0) begin dcm_locked = ($urandom_range(0, 9) < 8); hd = $urandom_range(1, 40); end
      if (hr == 0) begin
        resetdone = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom_range(0, 3));
        hr = $urandom_range(1, 30);
      end
      restart = ($urandom_range(0, 79) == 0);
      hp--; hd--; hr--;
      step(); total++;
      if (dut_vec() !== exp_out()) begin bad++; $display("FAIL random_c%0d got=%h exp=%h", c, dut_vec(), exp_out()); end
    end
    restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_timeout();
    test_dcm_drop();
    test_done_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
